// File: rtl/event_serializer.sv
// Serializing event transmitter: packs {x,y,p,t} into a byte, drops null events,
// buffers in a small FIFO and sends each byte as start + 8 data (LSB first) + stop.
module event_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] x_in,
  input  logic [1:0] y_in,
  input  logic [1:0] p_in,
  input  logic [1:0] t_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic [7:0] drop_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;

  logic [7:0]      word;
  logic            evt;
  logic            push;
  logic            drop;
  logic            pop;
  logic            fifo_nonempty;
  logic            baud_done;

  // Handshake: an event is taken at a rising edge when in_valid is high, the
  // packed word is non-zero and in_ready is high; with in_ready low it is dropped.
  assign word          = {x_in, y_in, p_in, t_in};
  assign evt           = in_valid && (word != 8'h00);
  assign in_ready      = (fifo_count != CW'(FIFO_DEPTH));
  assign push          = evt && in_ready;
  assign drop          = evt && !in_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign baud_done     = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign pop           = fifo_nonempty && ((state == IDLE) || (state == STOP && baud_done));
  assign tx_busy       = (state != IDLE) || fifo_nonempty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

  // Line driver: tx_out is loaded one edge ahead of each bit so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= 8'h00;
      tx_out   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (fifo_nonempty) begin
            shreg    <= mem[rd_ptr];
            tx_out   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_out   <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              tx_out  <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_out  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (fifo_nonempty) begin
              shreg  <= mem[rd_ptr];
              tx_out <= 1'b0;
              state  <= START;
            end else begin
              tx_out <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx_out <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
